// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus between the pipeline and the PC/fetch sequencer.
// The master drives redirect/flow-control requests; the slave returns fetch status.
interface pc_fetch_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             PC_STALL;
  logic             IMEM_READY;
  logic             TRAP_VALID;
  logic [XLEN-1:0]  TRAP_VEC;
  logic             MRET_VALID;
  logic [XLEN-1:0]  MRET_EPC;
  logic             BR_VALID;
  logic [XLEN-1:0]  BR_TARGET;
  logic [XLEN-1:0]  PC_COUNT;
  logic [XLEN-1:0]  PC_PLUS_INC;
  logic             FETCH_VALID;
  logic             MISALIGN;
  logic [XLEN-1:0]  MISALIGN_ADDR;
  logic [CNT_W-1:0] FETCH_CNT;

  modport master (
    output PC_STALL, IMEM_READY, TRAP_VALID, TRAP_VEC, MRET_VALID, MRET_EPC,
           BR_VALID, BR_TARGET,
    input  PC_COUNT, PC_PLUS_INC, FETCH_VALID, MISALIGN, MISALIGN_ADDR, FETCH_CNT
  );

  modport slave (
    input  PC_STALL, IMEM_READY, TRAP_VALID, TRAP_VEC, MRET_VALID, MRET_EPC,
           BR_VALID, BR_TARGET,
    output PC_COUNT, PC_PLUS_INC, FETCH_VALID, MISALIGN, MISALIGN_ADDR, FETCH_CNT
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter with prioritised redirects (trap > mret > branch), backpressure
// handling, misaligned-target trapping into HALT, and a saturating fetch counter.
//
// state | meaning
// BOOT  | single cycle after reset release, no fetch, redirects ignored
// RUN   | fetching; PC advances on accepted fetch or redirect
// HALT  | parked after a misaligned redirect; only a trap restarts fetching
module pc_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC       = 4,
  parameter int              CNT_W     = 32
) (
  input  logic          clk,
  input  logic          RST_N,
  pc_fetch_unit_if.slave bus
);

  localparam int ALIGN_W = (INC == 2) ? 1 : 2;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t           r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_fetch_valid;
  logic             r_misalign;
  logic [XLEN-1:0]  r_misalign_addr;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic [XLEN-1:0]  w_pc_plus_inc;
  logic [XLEN-1:0]  w_trap_tgt;
  logic [XLEN-1:0]  w_redir_tgt;
  logic             w_redir_mis;
  logic             w_accept;

  assign w_pc_plus_inc = r_pc + XLEN'(INC);
  assign w_trap_tgt    = {bus.TRAP_VEC[XLEN-1:ALIGN_W], {ALIGN_W{1'b0}}};
  // mret outranks branch, so only the winning non-trap target is alignment-checked
  assign w_redir_tgt   = bus.MRET_VALID ? bus.MRET_EPC : bus.BR_TARGET;
  assign w_redir_mis   = |w_redir_tgt[ALIGN_W-1:0];
  assign w_accept      = (r_state == RUN) && r_fetch_valid && bus.IMEM_READY && !bus.PC_STALL;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state         <= BOOT;
      r_pc            <= RESET_VEC;
      r_fetch_valid   <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
      r_fetch_cnt     <= '0;
    end else begin
      r_misalign <= 1'b0;
      if (w_accept && (r_fetch_cnt != {CNT_W{1'b1}}))
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);

      case (r_state)
        BOOT: begin
          r_state       <= RUN;
          r_fetch_valid <= 1'b1;
        end
        RUN: begin
          if (bus.TRAP_VALID) begin
            r_pc <= w_trap_tgt;
          end else if (bus.MRET_VALID || bus.BR_VALID) begin
            if (w_redir_mis) begin
              r_misalign      <= 1'b1;
              r_misalign_addr <= w_redir_tgt;
              r_state         <= HALT;
              r_fetch_valid   <= 1'b0;
            end else begin
              r_pc <= w_redir_tgt;
            end
          end else if (w_accept) begin
            r_pc <= w_pc_plus_inc;
          end
        end
        HALT: begin
          if (bus.TRAP_VALID) begin
            r_pc          <= w_trap_tgt;
            r_state       <= RUN;
            r_fetch_valid <= 1'b1;
          end
        end
        default: begin
          r_state       <= BOOT;
          r_fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC_COUNT      = r_pc;
  assign bus.PC_PLUS_INC   = w_pc_plus_inc;
  assign bus.FETCH_VALID   = r_fetch_valid;
  assign bus.MISALIGN      = r_misalign;
  assign bus.MISALIGN_ADDR = r_misalign_addr;
  assign bus.FETCH_CNT     = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector table plus hand-written sequences for pc_fetch_unit
// (RESET_VEC=0x100, INC=4, CNT_W=4 so counter saturation is reachable).
module tb_pc_fetch_unit;

  logic clk;
  logic RST_N;
  int   n_cmp;
  int   n_err;

  pc_fetch_unit_if #(.XLEN(32), .CNT_W(4)) bus ();

  pc_fetch_unit #(
    .XLEN(32), .RESET_VEC(32'h0000_0100), .INC(4), .CNT_W(4)
  ) dut (
    .clk  (clk),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, ready, trap, mret, br;
    logic [31:0] tvec, epc, tgt;
    logic [31:0] e_pc;
    logic        e_fv, e_mis;
    logic [31:0] e_maddr;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic stall, logic ready,
                              logic trap, logic [31:0] tvec,
                              logic mret, logic [31:0] epc,
                              logic br, logic [31:0] tgt,
                              logic [31:0] e_pc, logic e_fv, logic e_mis,
                              logic [31:0] e_maddr, logic [3:0] e_cnt);
    vec_t v;
    v.stall = stall; v.ready = ready; v.trap = trap; v.tvec = tvec;
    v.mret = mret; v.epc = epc; v.br = br; v.tgt = tgt;
    v.e_pc = e_pc; v.e_fv = e_fv; v.e_mis = e_mis; v.e_maddr = e_maddr; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic stall, logic ready, logic trap, logic [31:0] tvec,
                       logic mret, logic [31:0] epc, logic br, logic [31:0] tgt);
    bus.PC_STALL = stall; bus.IMEM_READY = ready;
    bus.TRAP_VALID = trap; bus.TRAP_VEC = tvec;
    bus.MRET_VALID = mret; bus.MRET_EPC = epc;
    bus.BR_VALID = br; bus.BR_TARGET = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  m_cnt;
    logic [31:0] m_pc;
    n_cmp = 0;
    n_err = 0;

    //            stl rdy trp tvec           mrt epc            br  tgt            e_pc           fv mis maddr          cnt
    tbl[0]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0500, 32'h0000_0100, 1, 0, 32'h0,          4'd0);
    tbl[1]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0104, 1, 0, 32'h0,          4'd1);
    tbl[2]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0108, 1, 0, 32'h0,          4'd2);
    tbl[3]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_010C, 1, 0, 32'h0,          4'd3);
    tbl[4]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0200, 32'h0000_0200, 1, 0, 32'h0,          4'd4);
    tbl[5]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0200, 1, 0, 32'h0,          4'd4);
    tbl[6]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0200, 1, 0, 32'h0,          4'd4);
    tbl[7]  = mk(0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0200, 1, 0, 32'h0,          4'd4);
    tbl[8]  = mk(1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0200, 1, 0, 32'h0,          4'd4);
    tbl[9]  = mk(1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0200, 1, 0, 32'h0,          4'd4);
    tbl[10] = mk(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0204, 1, 0, 32'h0,          4'd5);
    tbl[11] = mk(1, 1, 1, 32'h0000_0803, 1, 32'h0000_0900, 1, 32'h0000_0A00, 32'h0000_0800, 1, 0, 32'h0,          4'd5);
    tbl[12] = mk(0, 0, 0, 32'h0,          1, 32'h0000_0300, 1, 32'h0000_0400, 32'h0000_0300, 1, 0, 32'h0,          4'd5);
    tbl[13] = mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_1002, 32'h0000_0300, 0, 1, 32'h0000_1002, 4'd5);
    tbl[14] = mk(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0600, 32'h0000_0300, 0, 0, 32'h0000_1002, 4'd5);
    tbl[15] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0700, 0, 32'h0,          32'h0000_0300, 0, 0, 32'h0000_1002, 4'd5);
    tbl[16] = mk(0, 0, 1, 32'h0000_0040, 0, 32'h0,          0, 32'h0,          32'h0000_0040, 1, 0, 32'h0000_1002, 4'd5);
    tbl[17] = mk(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0044, 1, 0, 32'h0000_1002, 4'd6);
    tbl[18] = mk(0, 1, 0, 32'h0,          1, 32'h0000_0702, 0, 32'h0,          32'h0000_0044, 0, 1, 32'h0000_0702, 4'd7);
    tbl[19] = mk(0, 1, 1, 32'h0000_0013, 0, 32'h0,          0, 32'h0,          32'h0000_0010, 1, 0, 32'h0000_0702, 4'd7);
    tbl[20] = mk(0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0,          0, 32'h0,          32'hFFFF_FFFC, 1, 0, 32'h0000_0702, 4'd7);
    tbl[21] = mk(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0000, 1, 0, 32'h0000_0702, 4'd8);
    tbl[22] = mk(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0000_0004, 1, 0, 32'h0000_0702, 4'd9);

    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    RST_N = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST_N = 1'b1;
    #1;
    chk("boot_pc", bus.PC_COUNT, 32'h0000_0100);
    chk("boot_fv", 32'(bus.FETCH_VALID), 32'd0);
    chk("boot_mis", 32'(bus.MISALIGN), 32'd0);
    chk("boot_maddr", bus.MISALIGN_ADDR, 32'h0);
    chk("boot_cnt", 32'(bus.FETCH_CNT), 32'd0);

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].stall, tbl[i].ready, tbl[i].trap, tbl[i].tvec,
            tbl[i].mret, tbl[i].epc, tbl[i].br, tbl[i].tgt);
      tick();
      chk($sformatf("v%0d_pc", i), bus.PC_COUNT, tbl[i].e_pc);
      chk($sformatf("v%0d_ppi", i), bus.PC_PLUS_INC, tbl[i].e_pc + 32'd4);
      chk($sformatf("v%0d_fv", i), 32'(bus.FETCH_VALID), 32'(tbl[i].e_fv));
      chk($sformatf("v%0d_mis", i), 32'(bus.MISALIGN), 32'(tbl[i].e_mis));
      chk($sformatf("v%0d_maddr", i), bus.MISALIGN_ADDR, tbl[i].e_maddr);
      chk($sformatf("v%0d_cnt", i), 32'(bus.FETCH_CNT), 32'(tbl[i].e_cnt));
    end

    // 20 back-to-back accepted fetches drive the 4-bit counter into saturation
    m_cnt = 4'd9;
    m_pc  = 32'h0000_0004;
    drive(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      tick();
      m_pc = m_pc + 32'd4;
      if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      chk($sformatf("sat%0d_cnt", k), 32'(bus.FETCH_CNT), 32'(m_cnt));
    end
    chk("sat_final_cnt", 32'(bus.FETCH_CNT), 32'd15);
    chk("sat_pc", bus.PC_COUNT, m_pc);

    // misaligned branch parks the unit in HALT, then reset hits mid-cycle
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0000_1001);
    tick();
    chk("halt_mis", 32'(bus.MISALIGN), 32'd1);
    chk("halt_maddr", bus.MISALIGN_ADDR, 32'h0000_1001);
    chk("halt_pc", bus.PC_COUNT, m_pc);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    chk("halt_fv", 32'(bus.FETCH_VALID), 32'd0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_pc", bus.PC_COUNT, 32'h0000_0100);
    chk("arst_fv", 32'(bus.FETCH_VALID), 32'd0);
    chk("arst_maddr", bus.MISALIGN_ADDR, 32'h0);
    chk("arst_cnt", 32'(bus.FETCH_CNT), 32'd0);
    drive(0, 1, 1, 32'h0000_0800, 0, 32'h0, 0, 32'h0);
    tick();
    chk("arst_hold_pc", bus.PC_COUNT, 32'h0000_0100);
    @(negedge clk);
    RST_N = 1'b1;
    tick();
    chk("reboot_pc", bus.PC_COUNT, 32'h0000_0100);
    chk("reboot_fv", 32'(bus.FETCH_VALID), 32'd1);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick();
    chk("reboot_adv_pc", bus.PC_COUNT, 32'h0000_0104);
    chk("reboot_adv_cnt", 32'(bus.FETCH_CNT), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter and fetch-sequencing block that replaces the plain PC register in the fetch stage. It generates the sequential next PC internally and arbitrates redirect sources by priority: trap, then mret, then branch/jump. It also handles instruction-memory backpressure and stalls, detects misaligned redirect targets, and counts accepted fetches. It drives the instruction-memory address and the PC+INC value used by the link and writeback paths.

Parameters:
XLEN, 32, width of PC and all address ports
RESET_VEC, 32'h0000_0000, PC value loaded on reset
INC, 4, sequential increment in bytes; legal values are 2 and 4
CNT_W, 32, width of the fetch counter

Ports:
clk  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
PC_STALL  in  1  pipeline hold; blocks sequential advance
IMEM_READY  in  1  instruction memory accepts the current fetch address this cycle
TRAP_VALID  in  1  trap redirect request
TRAP_VEC  in  XLEN  trap target; low log2(INC) bits are forced to zero internally
MRET_VALID  in  1  return-from-trap redirect request
MRET_EPC  in  XLEN  return target
BR_VALID  in  1  branch/jump redirect request
BR_TARGET  in  XLEN  branch/jump target
PC_COUNT  out  XLEN  current fetch address (registered)
PC_PLUS_INC  out  XLEN  PC_COUNT+INC, combinational, wraps modulo 2^XLEN
FETCH_VALID  out  1  PC_COUNT is a live fetch request
MISALIGN  out  1  one-cycle pulse on misaligned redirect
MISALIGN_ADDR  out  XLEN  offending target, held until the next misalign event or reset
FETCH_CNT  out  CNT_W  accepted-fetch count, saturating

Behaviour:
- Reset (RST_N=0, asynchronous): PC_COUNT=RESET_VEC, FSM=BOOT, FETCH_VALID=0, MISALIGN=0, MISALIGN_ADDR=0, FETCH_CNT=0.
- Reset asserted mid-operation aborts everything immediately, including a pending redirect or HALT.
- FSM states: BOOT, RUN, HALT.
  - BOOT: exactly one cycle after reset release. FETCH_VALID=0. Redirect inputs are ignored. Next state is always RUN.
  - RUN: FETCH_VALID=1.
  - HALT: FETCH_VALID=0, PC_COUNT holds. Only TRAP_VALID is honoured; it loads the aligned TRAP_VEC and moves to RUN. MRET_VALID and BR_VALID are ignored.
- Accepted fetch is defined as FSM=RUN and FETCH_VALID and IMEM_READY and !PC_STALL.
- Next-PC selection in RUN, evaluated at each rising clk, in priority order:
  1. TRAP_VALID: load aligned TRAP_VEC.
  2. MRET_VALID: load MRET_EPC.
  3. BR_VALID: load BR_TARGET.
  4. Accepted fetch: load PC_COUNT+INC.
  5. Otherwise: hold.
- Redirects (1–3) override PC_STALL and IMEM_READY; the flush wins over a hold.
- Simultaneous redirect requests: only the highest-priority one takes effect; the others are dropped, not queued.
- Misalignment check applies to MRET_EPC and BR_TARGET only, on the selected source. A target is misaligned when (target mod INC) != 0.
  - On a misaligned target: PC_COUNT holds, MISALIGN=1 for one cycle, MISALIGN_ADDR<=target, FSM->HALT.
  - Trap targets cannot misalign because their low bits are forced to zero.
- Latency: a redirect asserted in cycle N appears on PC_COUNT in cycle N+1. A sequential advance also has 1-cycle latency.
- Wrap-around: PC_COUNT=2^XLEN-INC advances to 0 with no flag.
- FETCH_CNT: increments by 1 on each accepted fetch (including the accepted fetch in the same cycle as a redirect) and saturates at 2^CNT_W-1. A redirect cycle with no accepted fetch does not count.
- All outputs except PC_PLUS_INC are registered.

Test Plan:
- Reset release with RESET_VEC=0x100 and IMEM_READY=1 -> cycle 1: FETCH_VALID=0, PC=0x100; cycles 2..4: PC=0x100, 0x104, 0x108; FETCH_CNT=3 after cycle 4.
- PC=0x200 in RUN, IMEM_READY=0 for 3 cycles, then PC_STALL=1 for 2 cycles -> PC holds at 0x200 and FETCH_CNT does not change; PC reaches 0x204 one cycle after both inputs clear.
- TRAP_VALID with TRAP_VEC=0x803, MRET_VALID and BR_VALID asserted in the same cycle, PC_STALL=1 -> next PC=0x800; MISALIGN stays 0.
- BR_VALID with BR_TARGET=0x1002, INC=4 -> MISALIGN pulses once, MISALIGN_ADDR=0x1002, PC holds, FETCH_VALID=0. A later BR_VALID is ignored. TRAP_VALID with TRAP_VEC=0x40 -> PC=0x40, back to RUN.
- XLEN=32, PC=0xFFFF_FFFC, accepted fetch -> PC=0x0000_0000. With CNT_W=4 and 20 accepted fetches -> FETCH_CNT=15.
- RST_N pulsed low mid-cycle while in HALT -> PC=RESET_VEC, FETCH_VALID=0, and MISALIGN_ADDR=0 immediately, without waiting for a clock edge.
